adder_arbiter: RTL and testbench



---
 rtl/adder_arbiter.sv | 179 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one registered adder among requesters
//
// Grants one requester at a time access to a shared adder that registers its
// sum (one-cycle latency) but presents its carry combinationally. The carry is
// captured in the cycle the operands are first presented, and the sum one
// cycle later, so both belong to the same operand pair. The result is returned
// as {id, sum, carry} on a valid/ready response channel.
//
// Configuration macro:
//   ADDER_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                            undefined -> round-robin (default)
//
// Ports:
//   clk            rising-edge clock
//   rst_ni         synchronous active-low reset
//   req_valid_i    per-requester request valid
//   req_ready_o    per-requester accept, one-hot or zero, only in IDLE
//   req_a_i        operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b_i        operand B, same packing
//   resp_valid_o   response valid
//   resp_ready_i   response consumer ready
//   resp_id_o      requester index owning the response
//   resp_sum_o     sum
//   resp_carry_o   carry out
//   add_a_o        to shared adder operand A
//   add_b_o        to shared adder operand B
//   add_sum_i      from shared adder sum (registered)
//   add_carry_i    from shared adder carry (combinational)
//   busy_o         high whenever a transaction is in flight

module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [IDW-1:0]           resp_id_o,
  output logic [WIDTH-1:0]         resp_sum_o,
  output logic                     resp_carry_o,
  output logic [WIDTH-1:0]         add_a_o,
  output logic [WIDTH-1:0]         add_b_o,
  input  logic [WIDTH-1:0]         add_sum_i,
  input  logic                     add_carry_i,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [IDW-1:0]   id_q;
  logic             carry_q;
  logic             resp_valid_q;
  logic [IDW-1:0]   resp_id_q;
  logic [WIDTH-1:0] resp_sum_q;
  logic             resp_carry_q;
`ifndef ADDER_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   rr_ptr_q;
`endif

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             accept;

  // Grant search. In round-robin mode the search starts at rr_ptr and wraps;
  // in fixed mode it always starts at 0. Evaluated every cycle so a withdrawn
  // request simply drops out of the next IDLE decision.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
`ifdef ADDER_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
`endif
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  assign accept = (state_q == S_IDLE) && grant_found;

  // Ready is only ever raised in IDLE, which keeps exactly one transaction in
  // flight without any extra bookkeeping.
  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      id_q         <= '0;
      carry_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_carry_q <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_a_q  <= req_a_i[int'(grant_idx)*WIDTH +: WIDTH];
            op_b_q  <= req_b_i[int'(grant_idx)*WIDTH +: WIDTH];
            id_q    <= grant_idx;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Operands reach the adder this cycle; its carry is valid now,
          // while its sum only appears after this edge.
          carry_q <= add_carry_i;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          resp_sum_q   <= add_sum_i;
          resp_carry_q <= carry_q;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            // Pointer advances only on completion, so a stalled response
            // holds off every requester, including the next in line.
            if (id_q == IDW'(NUM_REQ - 1)) begin
              rr_ptr_q <= '0;
            end else begin
              rr_ptr_q <= id_q + IDW'(1);
            end
`endif
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign add_a_o      = op_a_q;
  assign add_b_o      = op_b_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_sum_o   = resp_sum_q;
  assign resp_carry_o = resp_carry_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized bench for adder_arbiter with transaction-level reference model

module tb_adder_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [IDW-1:0]   resp_id;
  logic [W-1:0]     resp_sum;
  logic             resp_carry;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [W-1:0]     add_sum;
  logic             add_carry;
  logic             busy;
  logic [W:0]       add_full;

  always #5 clk = ~clk;

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_sum_o   (resp_sum),
    .resp_carry_o (resp_carry),
    .add_a_o      (add_a),
    .add_b_o      (add_b),
    .add_sum_i    (add_sum),
    .add_carry_i  (add_carry),
    .busy_o       (busy)
  );

  // Shared adder: registered sum, combinational carry.
  assign add_full  = {1'b0, add_a} + {1'b0, add_b};
  assign add_carry = add_full[W];
  always @(posedge clk) add_sum <= add_full[W-1:0];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference model, sampled mid-cycle.
  int         cyc = 0;
  bit         m_busy = 0;
  bit         m_fresh = 0;
  int         m_rr = 0;
  int         m_age = 0;
  int         m_id = 0;
  logic [W-1:0] m_a, m_b;
  logic [W:0]   m_sum;
  int         grant_q[$];
  int         acc_q[$];
  int         n_resp = 0;
  int         last_id = 0;
  logic [W-1:0] last_sum = '0;
  logic       last_carry = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_ni) begin
      m_busy  = 0;
      m_rr    = 0;
      m_fresh = 1;
    end else begin
      if (m_fresh) begin
        check_eq("rst_add_a", 32'(add_a), 32'd0);
        check_eq("rst_add_b", 32'(add_b), 32'd0);
        check_eq("rst_resp_id", 32'(resp_id), 32'd0);
        check_eq("rst_resp_sum", 32'(resp_sum), 32'd0);
        check_eq("rst_resp_carry", 32'(resp_carry), 32'd0);
        m_fresh = 0;
      end
      if (!m_busy) begin
        int g;
        logic [N-1:0] exp_ready;
        g = -1;
        for (int k = 0; k < N; k++) begin
          int idx;
`ifdef ADDER_ARB_FIXED_PRIO_EN
          idx = k;
`else
          idx = (m_rr + k) % N;
`endif
          if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq("idle_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_req_ready", 32'(req_ready), 32'(exp_ready));
        if (g >= 0) begin
          m_busy = 1;
          m_age  = 0;
          m_id   = g;
          m_a    = req_a[g*W +: W];
          m_b    = req_b[g*W +: W];
          m_sum  = {1'b0, m_a} + {1'b0, m_b};
          grant_q.push_back(g);
          acc_q.push_back(cyc);
        end
      end else begin
        m_age++;
        check_eq("fly_req_ready", 32'(req_ready), 32'd0);
        check_eq("fly_busy", 32'(busy), 32'd1);
        check_eq("fly_add_a", 32'(add_a), 32'(m_a));
        check_eq("fly_add_b", 32'(add_b), 32'(m_b));
        if (m_age < 3) begin
          check_eq("early_resp_valid", 32'(resp_valid), 32'd0);
        end else begin
          check_eq("resp_valid", 32'(resp_valid), 32'd1);
          check_eq("resp_id", 32'(resp_id), 32'(m_id));
          check_eq("resp_sum", 32'(resp_sum), 32'(m_sum[W-1:0]));
          check_eq("resp_carry", 32'(resp_carry), 32'(m_sum[W]));
          if (resp_ready) begin
            last_id    = int'(resp_id);
            last_sum   = resp_sum;
            last_carry = resp_carry;
            n_resp++;
            m_busy = 0;
            m_rr   = (m_id + 1) % N;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  int exp_order[5];
  int base_resp;
  int base_grants;

  initial begin
    rst_ni     = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    repeat (3) tick();
    rst_ni = 1'b1;

    // Single requester 2, plain add.
    set_ops(2, 16'h1234, 16'h0001);
    req_valid = 4'b0100;
    base_resp = n_resp;
    tick();
    req_valid = '0;
    repeat (5) tick();
    check_eq("t1_count", 32'(n_resp - base_resp), 32'd1);
    check_eq("t1_id", 32'(last_id), 32'd2);
    check_eq("t1_sum", 32'(last_sum), 32'h1235);
    check_eq("t1_carry", 32'(last_carry), 32'd0);

    // Carry-producing add.
    set_ops(0, 16'hFFFF, 16'h0001);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (5) tick();
    check_eq("t2_id", 32'(last_id), 32'd0);
    check_eq("t2_sum", 32'(last_sum), 32'h0000);
    check_eq("t2_carry", 32'(last_carry), 32'd1);

    // All requesters held valid after reset: grant order and spacing.
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    grant_q.delete();
    acc_q.delete();
    req_valid = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom));
      tick();
    end
    req_valid = '0;
    repeat (5) tick();
`ifdef ADDER_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    check_eq("t3_grants", 32'(grant_q.size() >= 5), 32'd1);
    if (grant_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) check_eq("t3_order", 32'(grant_q[i]), 32'(exp_order[i]));
      for (int i = 0; i < 4; i++) check_eq("t3_spacing", 32'(acc_q[i+1] - acc_q[i]), 32'd4);
    end

    // Response backpressure with other requesters pending.
    set_ops(1, W'($urandom), W'($urandom));
    req_valid  = 4'b0010;
    resp_ready = 1'b0;
    tick();
    req_valid = 4'b1111;
    repeat (8) tick();
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (4) tick();
    check_eq("t4_id", 32'(last_id), 32'd1);

    // Reset while waiting on the sum: dropped, then rr restarts at 0.
    set_ops(2, W'($urandom), W'($urandom));
    set_ops(1, W'($urandom), W'($urandom));
    set_ops(3, W'($urandom), W'($urandom));
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    rst_ni    = 1'b0;
    base_resp = n_resp;
    tick();
    rst_ni      = 1'b1;
    req_valid   = 4'b1010;
    base_grants = grant_q.size();
    tick();
    req_valid = '0;
    repeat (5) tick();
    check_eq("t5_count", 32'(n_resp - base_resp), 32'd1);
    check_eq("t5_grant", 32'(grant_q[grant_q.size()-1]), 32'd1);
    check_eq("t5_id", 32'(last_id), 32'd1);
    check_eq("t5_ngrant", 32'(grant_q.size() - base_grants), 32'd1);

    // Random traffic with backpressure and occasional reset.
    base_resp = n_resp;
    for (int c = 0; c < 400; c++) begin
      req_valid  = N'($urandom_range(0, 15));
      resp_ready = ($urandom % 4) != 0;
      rst_ni     = ($urandom % 100) != 0;
      for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom));
      tick();
    end
    rst_ni     = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (6) tick();
    check_eq("rand_resp_seen", 32'(n_resp > base_resp + 20), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
